// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - state enum, opcode fields, ALU codes and cond codes for ctrl_fsm
// Macro CTRL_ILLEGAL_TRAP_EN adds the S_HALT state.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET_PC = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC     = 4'd3,
    S_WB       = 4'd4,
    S_MEM      = 4'd5,
    S_BRANCH   = 4'd6,
`ifdef CTRL_ILLEGAL_TRAP_EN
    S_PC_INC   = 4'd7,
    S_HALT     = 4'd8
`else
    S_PC_INC   = 4'd7
`endif
  } state_e;

  typedef enum logic [2:0] {
    CL_NOP, CL_ALU, CL_MEM, CL_BRANCH, CL_ILLEGAL
  } op_class_e;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  localparam logic [3:0] EXT_NOP   = 4'b0000;
  localparam logic [3:0] EXT_AND   = 4'b0001;
  localparam logic [3:0] EXT_OR    = 4'b0010;
  localparam logic [3:0] EXT_XOR   = 4'b0011;
  localparam logic [3:0] EXT_ADD   = 4'b0101;
  localparam logic [3:0] EXT_SUB   = 4'b1001;
  localparam logic [3:0] EXT_CMP   = 4'b1011;
  localparam logic [3:0] EXT_MOV   = 4'b1101;
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JCOND = 4'b1100;
  localparam logic [3:0] EXT_LSH   = 4'b0100;

  localparam logic [3:0] ALU_NOP    = 4'd0;
  localparam logic [3:0] ALU_ADD    = 4'd1;
  localparam logic [3:0] ALU_SUB    = 4'd2;
  localparam logic [3:0] ALU_AND    = 4'd3;
  localparam logic [3:0] ALU_OR     = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_PASS_B = 4'd6;
  localparam logic [3:0] ALU_LUI    = 4'd7;

  localparam logic [1:0] B_REG  = 2'd0;
  localparam logic [1:0] B_SIGN = 2'd1;
  localparam logic [1:0] B_ONE  = 2'd2;
  localparam logic [1:0] B_ZERO = 2'd3;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_GT = 4'b0110;
  localparam logic [3:0] COND_LE = 4'b0111;
  localparam logic [3:0] COND_LT = 4'b1100;
  localparam logic [3:0] COND_GE = 4'b1101;
  localparam logic [3:0] COND_UC = 4'b1110;

  function automatic op_class_e classify(input logic [3:0] op, input logic [3:0] ext);
    op_class_e cl;
    cl = CL_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (ext)
          EXT_NOP: cl = CL_NOP;
          EXT_ADD, EXT_SUB, EXT_CMP, EXT_AND, EXT_OR, EXT_XOR, EXT_MOV: cl = CL_ALU;
          default: cl = CL_ILLEGAL;
        endcase
      end
      OP_ADDI, OP_SUBI, OP_CMPI, OP_ANDI, OP_ORI, OP_XORI, OP_MOVI, OP_LUI: cl = CL_ALU;
      OP_SHIFT: begin
        if ((ext == EXT_LSH) || (ext[3:1] == 3'b000)) cl = CL_ALU;
      end
      OP_MEM: begin
        if ((ext == EXT_LOAD) || (ext == EXT_STOR)) cl = CL_MEM;
        else if (ext == EXT_JCOND) cl = CL_BRANCH;
      end
      OP_BCOND: cl = CL_BRANCH;
      default: cl = CL_ILLEGAL;
    endcase
    return cl;
  endfunction

endpackage

// File: rtl/ctrl_fsm_cond_eval.sv
// rtl/ctrl_fsm_cond_eval.sv - branch condition code against the ALU flags
module cond_eval
  import ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic       flag_c_i,
  input  logic       flag_z_i,
  input  logic       flag_n_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      COND_EQ: taken_o = flag_z_i;
      COND_NE: taken_o = ~flag_z_i;
      COND_CS: taken_o = flag_c_i;
      COND_CC: taken_o = ~flag_c_i;
      COND_GT: taken_o = flag_n_i;
      COND_LE: taken_o = ~flag_n_i;
      COND_LT: taken_o = ~flag_n_i & ~flag_z_i;
      COND_GE: taken_o = flag_n_i | flag_z_i;
      COND_UC: taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// rtl/ctrl_fsm.sv - multicycle control FSM for the 16-bit datapath, owns the memory handshake
// Macro CTRL_ILLEGAL_TRAP_EN: undecoded opcodes trap into HALT and raise illegal_op.
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter logic [15:0] PC_RESET    = 16'h0000,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr_in,
  input  logic        mem_ready,
  input  logic        flag_c,
  input  logic        flag_l,
  input  logic        flag_f,
  input  logic        flag_z,
  input  logic        flag_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_en,
  output logic        pc_reg_en,
  output logic        src_reg_en,
  output logic        dst_reg_en,
  output logic        imm_reg_en,
  output logic        result_reg_en,
  output logic        sign_en,
  output logic        reg_file_en,
  output logic        flag_en,
  output logic        pc_reg_mux_sel,
  output logic [1:0]  alu_b_sel,
  output logic        reg_imm_sel,
  output logic        shift_alu_sel,
  output logic [3:0]  alu_control,
  output logic        mem_err,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic        illegal_op,
`endif
  output logic        busy
);

  // The PC is loaded through ALU PASS_B, so only the constant B inputs (0 or 1) are reachable.
  localparam logic [1:0]  PC_RESET_SRC = (PC_RESET == 16'h0001) ? B_ONE : B_ZERO;
  localparam logic [15:0] TMO_LIMIT    = 16'(MEM_TIMEOUT);
  localparam logic        TMO_ON       = (MEM_TIMEOUT != 0);

  state_e      state_q, state_d;
  logic [11:0] cmd_q, cmd_d;
  logic [15:0] tmo_q, tmo_d;

  logic [3:0]  op, cond, ext;
  op_class_e   op_class;
  logic        taken, tmo_hit, is_cmp, is_stor;
  logic [3:0]  ex_alu;
  logic [1:0]  ex_bsel;
  logic        ex_sign, ex_flag, ex_shift, ex_rimm;
  logic        unused_inputs;

  assign op            = cmd_q[11:8];
  assign cond          = cmd_q[7:4];
  assign ext           = cmd_q[3:0];
  assign op_class      = classify(op, ext);
  assign is_cmp        = (op == OP_CMPI) || ((op == OP_RTYPE) && (ext == EXT_CMP));
  assign is_stor       = (ext == EXT_STOR);
  assign tmo_hit       = TMO_ON && (tmo_q == TMO_LIMIT);
  assign unused_inputs = ^{flag_l, flag_f, instr_in[3:0]};

  cond_eval u_cond_eval (
    .cond_i   (cond),
    .flag_c_i (flag_c),
    .flag_z_i (flag_z),
    .flag_n_i (flag_n),
    .taken_o  (taken)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RESET_PC;
      cmd_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      tmo_q   <= tmo_d;
    end
  end

  // EXEC-cycle datapath controls decoded from the latched op/op-ext
  always_comb begin
    ex_alu   = ALU_NOP;
    ex_bsel  = B_REG;
    ex_sign  = 1'b0;
    ex_flag  = 1'b0;
    ex_shift = 1'b0;
    ex_rimm  = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (ext)
          EXT_ADD: begin ex_alu = ALU_ADD; ex_flag = 1'b1; end
          EXT_SUB, EXT_CMP: begin ex_alu = ALU_SUB; ex_flag = 1'b1; end
          EXT_AND: ex_alu = ALU_AND;
          EXT_OR:  ex_alu = ALU_OR;
          EXT_XOR: ex_alu = ALU_XOR;
          EXT_MOV: ex_alu = ALU_PASS_B;
          default: ex_alu = ALU_NOP;
        endcase
      end
      OP_ADDI: begin ex_alu = ALU_ADD; ex_bsel = B_SIGN; ex_sign = 1'b1; ex_flag = 1'b1; end
      OP_SUBI, OP_CMPI: begin ex_alu = ALU_SUB; ex_bsel = B_SIGN; ex_sign = 1'b1; ex_flag = 1'b1; end
      OP_ANDI: begin ex_alu = ALU_AND; ex_bsel = B_SIGN; end
      OP_ORI:  begin ex_alu = ALU_OR;  ex_bsel = B_SIGN; end
      OP_XORI: begin ex_alu = ALU_XOR; ex_bsel = B_SIGN; end
      OP_MOVI: begin ex_alu = ALU_PASS_B; ex_bsel = B_SIGN; ex_sign = 1'b1; end
      OP_LUI:  begin ex_alu = ALU_LUI; ex_bsel = B_SIGN; ex_sign = 1'b1; end
      OP_SHIFT: begin
        ex_shift = 1'b1;
        ex_rimm  = (ext != EXT_LSH);
        ex_sign  = ex_rimm;
      end
      default: ex_alu = ALU_NOP;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    tmo_d          = '0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    addr_sel       = 1'b0;
    ir_en          = 1'b0;
    pc_reg_en      = 1'b0;
    src_reg_en     = 1'b0;
    dst_reg_en     = 1'b0;
    imm_reg_en     = 1'b0;
    result_reg_en  = 1'b0;
    sign_en        = 1'b0;
    reg_file_en    = 1'b0;
    flag_en        = 1'b0;
    pc_reg_mux_sel = 1'b0;
    alu_b_sel      = B_REG;
    reg_imm_sel    = 1'b0;
    shift_alu_sel  = 1'b0;
    alu_control    = ALU_NOP;
    mem_err        = 1'b0;
    busy           = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_op     = 1'b0;
`endif
    // Outputs follow reset combinationally so an asserted reset silences the bus at once.
    if (!reset) begin
      case (state_q)
        S_RESET_PC: begin
          busy        = 1'b1;
          pc_reg_en   = 1'b1;
          alu_b_sel   = PC_RESET_SRC;
          alu_control = ALU_PASS_B;
          state_d     = S_FETCH;
        end
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_en      = 1'b1;
            src_reg_en = 1'b1;
            dst_reg_en = 1'b1;
            imm_reg_en = 1'b1;
            cmd_d      = instr_in[15:4];
            state_d    = S_DECODE;
          end
        end
        S_DECODE: begin
          busy = 1'b1;
          case (op_class)
            CL_ALU:    state_d = S_EXEC;
            CL_MEM:    state_d = S_MEM;
            CL_BRANCH: state_d = S_BRANCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
            CL_ILLEGAL: state_d = S_HALT;
`endif
            default:   state_d = S_PC_INC;
          endcase
        end
        S_EXEC: begin
          busy          = 1'b1;
          result_reg_en = 1'b1;
          alu_control   = ex_alu;
          alu_b_sel     = ex_bsel;
          sign_en       = ex_sign;
          flag_en       = ex_flag;
          shift_alu_sel = ex_shift;
          reg_imm_sel   = ex_rimm;
          state_d       = is_cmp ? S_PC_INC : S_WB;
        end
        S_WB: begin
          busy        = 1'b1;
          reg_file_en = 1'b1;
          state_d     = S_PC_INC;
        end
        S_MEM: begin
          busy     = 1'b1;
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = is_stor;
          if (mem_ready) begin
            result_reg_en = ~is_stor;
            state_d       = is_stor ? S_PC_INC : S_WB;
          end else if (tmo_hit) begin
            mem_err = 1'b1;
            state_d = S_PC_INC;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end
        S_BRANCH: begin
          busy = 1'b1;
          if (taken) begin
            pc_reg_en = 1'b1;
            if (op == OP_BCOND) begin
              alu_b_sel   = B_SIGN;
              sign_en     = 1'b1;
              alu_control = ALU_ADD;
            end else begin
              alu_b_sel   = B_REG;
              alu_control = ALU_PASS_B;
            end
            state_d = S_FETCH;
          end else begin
            state_d = S_PC_INC;
          end
        end
        S_PC_INC: begin
          busy        = 1'b1;
          pc_reg_en   = 1'b1;
          alu_b_sel   = B_ONE;
          alu_control = ALU_ADD;
          state_d     = S_FETCH;
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        S_HALT: begin
          busy       = 1'b1;
          illegal_op = 1'b1;
        end
`endif
        default: state_d = S_RESET_PC;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb/tb_ctrl_fsm.sv - directed self-checking bench for ctrl_fsm
// Covers CTRL_ILLEGAL_TRAP_EN both defined and undefined.
module tb_ctrl_fsm;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr_in;
  logic        mem_ready;
  logic        flag_c, flag_l, flag_f, flag_z, flag_n;
  logic        mem_req, mem_we, addr_sel, ir_en, pc_reg_en, src_reg_en, dst_reg_en, imm_reg_en;
  logic        result_reg_en, sign_en, reg_file_en, flag_en, pc_reg_mux_sel;
  logic [1:0]  alu_b_sel;
  logic        reg_imm_sel, shift_alu_sel, mem_err, busy;
  logic [3:0]  alu_control;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic        illegal_op;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cnt_req, cnt_addr, cnt_we, cnt_err, cnt_wr, err_at;

  always #5 clk = ~clk;

  ctrl_fsm #(.PC_RESET(16'h0000), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .mem_ready(mem_ready),
    .flag_c(flag_c), .flag_l(flag_l), .flag_f(flag_f), .flag_z(flag_z), .flag_n(flag_n),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_en(ir_en),
    .pc_reg_en(pc_reg_en), .src_reg_en(src_reg_en), .dst_reg_en(dst_reg_en),
    .imm_reg_en(imm_reg_en), .result_reg_en(result_reg_en), .sign_en(sign_en),
    .reg_file_en(reg_file_en), .flag_en(flag_en), .pc_reg_mux_sel(pc_reg_mux_sel),
    .alu_b_sel(alu_b_sel), .reg_imm_sel(reg_imm_sel), .shift_alu_sel(shift_alu_sel),
    .alu_control(alu_control), .mem_err(mem_err),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
    #1;
  endtask

  // Called at a FETCH sample point; returns at the DECODE sample point.
  task automatic fetch(input logic [15:0] w);
    instr_in  = w;
    mem_ready = 1'b1;
    #1;
    chk("fetch_req", mem_req, 1'b1);
    chk("fetch_ir_en", ir_en, 1'b1);
    nx();
    mem_ready = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; instr_in = '0; mem_ready = 1'b0;
    flag_c = 0; flag_l = 0; flag_f = 0; flag_z = 0; flag_n = 0;
    nx(); nx();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_pc_en", pc_reg_en, 0);
    chk("rst_alu", alu_control, ALU_NOP);
    chk("rst_busy", busy, 0);
    chk("rst_bsel", alu_b_sel, 0);

    reset = 1'b0; #1;
    chk("pcrst_en", pc_reg_en, 1);
    chk("pcrst_bsel", alu_b_sel, 2'd3);
    chk("pcrst_alu", alu_control, ALU_PASS_B);
    nx();
    chk("fetch_idle_req", mem_req, 1);
    chk("fetch_idle_addr", addr_sel, 0);
    chk("fetch_idle_ir", ir_en, 0);
    chk("fetch_idle_busy", busy, 0);
    nx();
    // ADD R6,R1 with mem_ready left high through DECODE
    instr_in = 16'h0651; mem_ready = 1'b1; #1;
    chk("add_ir", ir_en, 1);
    chk("add_src", src_reg_en, 1);
    chk("add_imm", imm_reg_en, 1);
    nx();
    chk("dec_ir_ignored", ir_en, 0);
    chk("dec_req", mem_req, 0);
    chk("dec_busy", busy, 1);
    nx(); mem_ready = 1'b0; #1;
    chk("add_alu", alu_control, ALU_ADD);
    chk("add_flag", flag_en, 1);
    chk("add_res", result_reg_en, 1);
    chk("add_bsel", alu_b_sel, 0);
    chk("add_exec_wr", reg_file_en, 0);
    nx();
    chk("add_wb_wr", reg_file_en, 1);
    chk("add_wb_flag", flag_en, 0);
    nx();
    chk("add_inc_en", pc_reg_en, 1);
    chk("add_inc_bsel", alu_b_sel, 2);
    chk("add_inc_alu", alu_control, ALU_ADD);
    chk("add_inc_wr", reg_file_en, 0);
    nx();

    fetch(16'hD305);
    nx();
    chk("movi_sign", sign_en, 1);
    chk("movi_bsel", alu_b_sel, 1);
    chk("movi_alu", alu_control, ALU_PASS_B);
    chk("movi_flag", flag_en, 0);
    nx(); chk("movi_wb", reg_file_en, 1);
    nx(); nx();

    fetch(16'h13F0);
    nx();
    chk("andi_sign", sign_en, 0);
    chk("andi_bsel", alu_b_sel, 1);
    chk("andi_alu", alu_control, ALU_AND);
    nx(); nx(); nx();

    fetch(16'h02B1);
    nx();
    chk("cmp_alu", alu_control, ALU_SUB);
    chk("cmp_flag", flag_en, 1);
    nx();
    chk("cmp_inc_en", pc_reg_en, 1);
    chk("cmp_no_wr", reg_file_en, 0);
    nx();
    chk("cmp_fetch", mem_req, 1);

    flag_z = 1'b1;
    fetch(16'hC0FE);
    nx();
    chk("beq_t_en", pc_reg_en, 1);
    chk("beq_t_bsel", alu_b_sel, 1);
    chk("beq_t_mux", pc_reg_mux_sel, 0);
    chk("beq_t_alu", alu_control, ALU_ADD);
    chk("beq_t_flag", flag_en, 0);
    nx();
    chk("beq_t_fetch", mem_req, 1);

    flag_z = 1'b0;
    fetch(16'hC0FE);
    nx();
    chk("beq_nt_en", pc_reg_en, 0);
    nx();
    chk("beq_nt_inc", pc_reg_en, 1);
    chk("beq_nt_bsel", alu_b_sel, 2);
    nx();

    fetch(16'h4EC3);
    nx();
    chk("juc_en", pc_reg_en, 1);
    chk("juc_bsel", alu_b_sel, 0);
    chk("juc_alu", alu_control, ALU_PASS_B);
    nx();

    // LOAD: ready arrives on the fifth MEM cycle
    fetch(16'h4201);
    nx();
    cnt_req = 0; cnt_addr = 0; cnt_we = 0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) begin mem_ready = 1'b1; #1; end
      cnt_req  += int'(mem_req);
      cnt_addr += int'(addr_sel);
      cnt_we   += int'(mem_we);
      if (i == 5) chk("load_res", result_reg_en, 1);
      nx();
    end
    mem_ready = 1'b0; #1;
    chk("load_req_cycles", cnt_req, 5);
    chk("load_addr_cycles", cnt_addr, 5);
    chk("load_we_cycles", cnt_we, 0);
    chk("load_wb", reg_file_en, 1);
    nx(); chk("load_inc", pc_reg_en, 1);
    nx();

    // STOR with no ready: timeout on the 16th MEM cycle
    fetch(16'h4241);
    nx();
    cnt_err = 0; cnt_we = 0; cnt_wr = 0; err_at = 0;
    for (int i = 1; i <= 16; i++) begin
      if (mem_err) begin cnt_err++; err_at = i; end
      cnt_we += int'(mem_we);
      cnt_wr += int'(reg_file_en);
      nx();
    end
    chk("stor_err_count", cnt_err, 1);
    chk("stor_err_cycle", err_at, 16);
    chk("stor_we_cycles", cnt_we, 16);
    chk("stor_no_wr", cnt_wr, 0);
    chk("stor_inc", pc_reg_en, 1);
    chk("stor_inc_err", mem_err, 0);
    nx();

    // reset in the middle of a MEM cycle
    fetch(16'h4241);
    nx();
    chk("mid_mem_req", mem_req, 1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_addr", addr_sel, 0);
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_busy", busy, 0);
    nx();
    reset = 1'b0; #1;
    chk("mid_rst_pcload", pc_reg_en, 1);
    nx();

    fetch(16'h7000);
    nx();
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("halt_illegal", illegal_op, 1);
    chk("halt_busy", busy, 1);
    chk("halt_pc_en", pc_reg_en, 0);
    mem_ready = 1'b1;
    nx();
    chk("halt_stays", illegal_op, 1);
    chk("halt_no_req", mem_req, 0);
`else
    chk("nop_inc_en", pc_reg_en, 1);
    chk("nop_inc_bsel", alu_b_sel, 2);
    nx();
    chk("nop_fetch", mem_req, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
